// File: rtl/vram_block_mover.sv
// rtl/vram_block_mover.sv - copy/fill DMA engine for one video RAM port
`ifndef VIDEO_RAM_WIDTH
`define VIDEO_RAM_WIDTH 15
`endif

module vram_block_mover #(
    parameter int ADDR_WIDTH = `VIDEO_RAM_WIDTH,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op_fill,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [DATA_WIDTH-1:0] fill_val,
    input  logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        WRITE,
        FINISH
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cur_src;
    logic [ADDR_WIDTH-1:0] cur_dst;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] fill_val_q;
    logic                  fill_q;
    logic                  desc_q;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic [DATA_WIDTH-1:0] din_hold;
    logic                  done_q;
    logic                  accept;
    logic                  step;
    logic                  start_desc;
    logic [ADDR_WIDTH-1:0] len_m1;

    // Overlapping copies toward higher addresses must run from the top down.
    assign start_desc = !op_fill && (dst_addr > src_addr);
    assign len_m1     = ADDR_WIDTH'(len) - ADDR_WIDTH'(1);

    assign busy = (state != IDLE);
    assign done = done_q;

    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        ram_addr  = addr_hold;
        ram_din   = din_hold;
        accept    = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (len == '0)
                        state_nxt = FINISH;
                    else if (op_fill)
                        state_nxt = WRITE;
                    else
                        state_nxt = READ;
                end
            end
            READ: begin
                ram_addr = cur_src;
                if (!stall)
                    state_nxt = LATCH;
            end
            LATCH: begin
                ram_addr  = cur_src;
                state_nxt = WRITE;
            end
            WRITE: begin
                ram_addr = cur_dst;
                ram_din  = fill_q ? fill_val_q : data_q;
                ram_we   = !stall;
                if (!stall) begin
                    step = 1'b1;
                    if (remaining == LEN_WIDTH'(1))
                        state_nxt = FINISH;
                    else if (fill_q)
                        state_nxt = WRITE;
                    else
                        state_nxt = READ;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_src    <= '0;
            cur_dst    <= '0;
            remaining  <= '0;
            data_q     <= '0;
            fill_val_q <= '0;
            fill_q     <= 1'b0;
            desc_q     <= 1'b0;
            addr_hold  <= '0;
            din_hold   <= '0;
            done_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr_hold <= ram_addr;
            din_hold  <= ram_din;
            done_q    <= (state == FINISH);
            if (accept) begin
                fill_q     <= op_fill;
                fill_val_q <= fill_val;
                remaining  <= len;
                desc_q     <= start_desc;
                cur_src    <= start_desc ? src_addr + len_m1 : src_addr;
                cur_dst    <= start_desc ? dst_addr + len_m1 : dst_addr;
            end
            if (state == LATCH)
                data_q <= ram_dout;
            if (step) begin
                remaining <= remaining - LEN_WIDTH'(1);
                if (desc_q) begin
                    cur_src <= cur_src - ADDR_WIDTH'(1);
                    cur_dst <= cur_dst - ADDR_WIDTH'(1);
                end else begin
                    cur_src <= cur_src + ADDR_WIDTH'(1);
                    cur_dst <= cur_dst + ADDR_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_block_mover.sv
// tb/tb_vram_block_mover.sv - scoreboard bench for vram_block_mover
`timescale 1ns/1ps

module tb_vram_block_mover;

    localparam int AW    = 15;
    localparam int DEPTH = 1 << AW;
    localparam int MASK  = DEPTH - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          op_fill;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [15:0]   len;
    logic [7:0]    fill_val;
    logic          stall;
    logic          busy;
    logic          done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic [7:0]    ram_dout;

    logic          clr;
    logic          pre_we;
    logic [AW-1:0] pre_a;
    logic [7:0]    pre_d;

    logic [7:0]    tb_mem  [DEPTH];
    logic [7:0]    ref_mem [DEPTH];

    typedef struct {
        int a;
        int d;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  done_cnt = 0;

    always #5 clk = ~clk;

    vram_block_mover #(.ADDR_WIDTH(AW), .DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op_fill(op_fill),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
        .stall(stall), .busy(busy), .done(done), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Video RAM port B: synchronous read with one cycle of latency.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) tb_mem[i] <= 8'(i * 7 + 3);
        end else if (pre_we) begin
            tb_mem[pre_a] <= pre_d;
        end else if (ram_we) begin
            tb_mem[ram_addr] <= ram_din;
        end
        ram_dout <= tb_mem[ram_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write the DUT issues must be the next one the model predicted.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (ram_we) begin
            chk("we_during_stall", int'(stall), 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                         ram_addr, ram_din);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("write_addr", int'(ram_addr), w.a);
                chk("write_data", int'(ram_din), w.d);
            end
        end
    end

    // Reference: memmove semantics for copy, memset for fill; write order from the
    // direction rule. Only the first `limit` writes are predicted (-1 = all).
    task automatic model_job(input bit op, input int src, input int dst, input int n,
                             input int fv, input int limit);
        int  snap[$];
        int  cnt;
        bit  desc;
        wr_t list[$];
        cnt  = (limit < 0 || limit > n) ? n : limit;
        desc = !op && (dst > src);
        for (int i = 0; i < n; i++) snap.push_back(int'(ref_mem[(src + i) & MASK]));
        for (int j = 0; j < cnt; j++) begin
            int  idx;
            wr_t w;
            idx = desc ? n - 1 - j : j;
            w.a = (dst + idx) & MASK;
            w.d = op ? fv : snap[idx];
            list.push_back(w);
            exp_q.push_back(w);
        end
        foreach (list[i]) ref_mem[list[i].a] = 8'(list[i].d);
    endtask

    task automatic mem_compare(input string name);
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== ref_mem[i]) bad++;
        chk({"mem_", name}, bad, 0);
    endtask

    task automatic drive_job(input bit op, input int src, input int dst, input int n,
                             input int fv);
        start    = 1'b1;
        op_fill  = op;
        src_addr = AW'(src);
        dst_addr = AW'(dst);
        len      = 16'(n);
        fill_val = 8'(fv);
    endtask

    task automatic run_job(input string name, input bit op, input int src, input int dst,
                           input int n, input int fv, input int sa, input int sn,
                           input int xs, input int exp_busy);
        int k  = 0;
        int bc = 0;
        int d0;
        model_job(op, src, dst, n, fv, -1);
        d0 = done_cnt;
        @(posedge clk); #1;
        drive_job(op, src, dst, n, fv);
        @(posedge clk); #1;
        start    = 1'b0;
        op_fill  = 1'($urandom);
        src_addr = AW'($urandom);
        dst_addr = AW'($urandom);
        len      = 16'($urandom);
        fill_val = 8'($urandom);
        forever begin
            stall = (k >= sa) && (k < sa + sn);
            if (k == xs) drive_job(1'b1, 0, 'h3000, 4, 'h77);
            else start = 1'b0;
            @(negedge clk);
            if (!busy) break;
            bc++;
            if (bc > 2000) begin
                chk({"timeout_", name}, bc, exp_busy);
                break;
            end
            @(posedge clk); #1;
            k++;
        end
        stall = 1'b0;
        start = 1'b0;
        chk({"done_at_busy_low_", name}, int'(done), 1);
        chk({"busy_cycles_", name}, bc, exp_busy);
        @(posedge clk); #1;
        @(negedge clk);
        chk({"single_done_", name}, done_cnt - d0, 1);
        chk({"pending_writes_", name}, exp_q.size(), 0);
        mem_compare(name);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_fill = 1'b0; src_addr = '0; dst_addr = '0;
        len = '0; fill_val = '0; stall = 1'b0; clr = 1'b1; pre_we = 1'b0;
        pre_a = '0; pre_d = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i * 7 + 3);
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_we", int'(ram_we), 0);
        chk("reset_addr", int'(ram_addr), 0);
        chk("reset_din", int'(ram_din), 0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            pre_we = 1'b1; pre_a = AW'('h10 + i); pre_d = 8'(i + 1);
            ref_mem['h10 + i] = 8'(i + 1);
        end
        @(posedge clk); #1 pre_we = 1'b0;

        run_job("fill4", 1'b1, 0, 'h100, 4, 'hA5, 0, 0, -1, 5);
        chk("fill_below", int'(tb_mem['h0FF]), int'(8'('h0FF * 7 + 3)));
        chk("fill_above", int'(tb_mem['h104]), int'(8'('h104 * 7 + 3)));
        run_job("copy_up_overlap", 1'b0, 'h10, 'h12, 4, 0, 0, 0, -1, 13);
        chk("copy_top", int'(tb_mem['h15]), 4);
        run_job("copy_down_overlap", 1'b0, 'h12, 'h11, 4, 0, 0, 0, -1, 13);
        run_job("copy_same", 1'b0, 'h200, 'h200, 3, 0, 0, 0, -1, 10);
        run_job("fill_stall", 1'b1, 0, 'h240, 3, 'h3C, 1, 5, -1, 9);
        run_job("fill_wrap", 1'b1, 0, 'h7FFE, 4, 'hC3, 0, 0, -1, 5);
        run_job("len0", 1'b1, 0, 'h500, 0, 'h11, 0, 0, -1, 1);
        run_job("start_in_busy", 1'b1, 0, 'h600, 6, 'h22, 0, 0, 2, 7);
        run_job("start_in_finish", 1'b1, 0, 'h680, 3, 'h33, 0, 0, 3, 4);

        // Reset during byte 2 of an 8-byte ascending copy: only bytes 0 and 1 land.
        begin
            int d0;
            model_job(1'b0, 'h400, 'h300, 8, 0, 2);
            d0 = done_cnt;
            @(posedge clk); #1;
            drive_job(1'b0, 'h400, 'h300, 8, 0);
            @(posedge clk); #1 start = 1'b0;
            repeat (6) begin @(posedge clk); #1; end
            rst = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            chk("abort_busy", int'(busy), 0);
            chk("abort_we", int'(ram_we), 0);
            chk("abort_addr", int'(ram_addr), 0);
            @(posedge clk); #1 rst = 1'b0;
            repeat (4) @(negedge clk);
            chk("abort_no_done", done_cnt - d0, 0);
            chk("abort_pending", exp_q.size(), 0);
            mem_compare("abort");
        end
        run_job("after_abort", 1'b0, 'h400, 'h300, 8, 0, 0, 0, -1, 25);

        for (int t = 0; t < 24; t++) begin
            bit op;
            int n, s, d, sa, sn, eb;
            op = 1'($urandom_range(0, 1));
            n  = $urandom_range(0, 20);
            s  = $urandom_range(16, 'h6FFF);
            d  = $urandom_range(0, 1) ? s + $urandom_range(0, 16) - 8 : $urandom_range(0, 'h6FFF);
            sa = 0;
            sn = 0;
            if (op && n > 0) begin
                sa = $urandom_range(0, n - 1);
                sn = $urandom_range(0, 4);
            end
            eb = (n == 0) ? 1 : (op ? n + 1 + sn : 3 * n + 1);
            run_job($sformatf("rand%0d", t), op, s, d, n, $urandom_range(0, 255), sa, sn, -1, eb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
